sprite_layer_sequencer: RTL and testbench

Per-pixel scheduler that shares one sprite ROM between NUM_LAYERS sprite layers (player tank, enemy tanks, bullets, explosions) and selects one colour index for the downstream palette lookup. On each pixel_start it scans the hit layers in fixed priority order, reading each layer's ROM entry in turn. The first non-transparent index wins. If no layer hits, or every hit is transparent, the background index is emitted. It sits between the VGA pixel-position logic and the tank/bullet palette modules.

---
 rtl/sprite_seq_pkg.sv | 24 ++
 rtl/sprite_prio_enc.sv | 20 ++
 rtl/sprite_layer_sequencer.sv | 170 +++++++++++++++++
 tb/tb_sprite_layer_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_seq_pkg.sv
// Shared types and defaults for the sprite layer sequencer.
package sprite_seq_pkg;

  localparam int unsigned DEF_NUM_LAYERS      = 4;
  localparam int unsigned DEF_IDX_W           = 4;
  localparam int unsigned DEF_ADDR_W          = 10;
  localparam int unsigned DEF_TRANSPARENT_IDX = 0;

  // Scan sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // pix_layer code reported when the background wins: one past the last layer
  function automatic int unsigned bg_layer_code(input int unsigned num_layers);
    return num_layers;
  endfunction

  localparam int unsigned BG_LAYER_CODE = bg_layer_code(DEF_NUM_LAYERS);

endpackage

// File: rtl/sprite_prio_enc.sv
// Lowest-set-bit priority encoder; bit 0 is the highest priority layer.
module sprite_prio_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Scan from the top so the lowest set bit is the last (winning) assignment
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/sprite_layer_sequencer.sv
// Per-pixel sprite layer scheduler sharing one sprite ROM between layers.
// Optional build macro SPRITE_SEQ_OVERRUN_CNT_EN adds a saturating overrun counter;
// without it overrun_cnt is tied to zero.
module sprite_layer_sequencer
  import sprite_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS      = DEF_NUM_LAYERS,
  parameter int unsigned IDX_W           = DEF_IDX_W,
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned TRANSPARENT_IDX = DEF_TRANSPARENT_IDX
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           pixel_start,
  input  logic [NUM_LAYERS-1:0]          layer_hit,
  input  logic [NUM_LAYERS*ADDR_W-1:0]   layer_addr,
  input  logic [IDX_W-1:0]               bg_idx,
  output logic                           rom_req,
  output logic [$clog2(NUM_LAYERS)-1:0]  rom_layer,
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [IDX_W-1:0]               rom_data,
  output logic                           pix_valid,
  output logic [IDX_W-1:0]               pix_idx,
  output logic [$clog2(NUM_LAYERS):0]    pix_layer,
  output logic                           overrun,
  input  logic                           frame_start,
  output logic [7:0]                     overrun_cnt
);

  localparam int unsigned LAYER_W = $clog2(NUM_LAYERS);
  localparam int unsigned PL_W    = LAYER_W + 1;

  seq_state_t                   state, state_nxt;
  logic [NUM_LAYERS-1:0]        pend_mask, pend_nxt;
  logic [NUM_LAYERS*ADDR_W-1:0] addr_lat, addr_nxt;
  logic [IDX_W-1:0]             bg_lat, bg_nxt;

  logic                         rom_req_nxt;
  logic [LAYER_W-1:0]           rom_layer_nxt;
  logic [ADDR_W-1:0]            rom_addr_nxt;
  logic                         pix_valid_nxt;
  logic [IDX_W-1:0]             pix_idx_nxt;
  logic [PL_W-1:0]              pix_layer_nxt;
  logic                         overrun_nxt;
  logic                         ovr_evt;

  logic                         enc_any;
  logic [LAYER_W-1:0]           enc_idx;

  sprite_prio_enc #(
    .N  (NUM_LAYERS),
    .IW (LAYER_W)
  ) u_prio_enc (
    .req (pend_mask),
    .any (enc_any),
    .idx (enc_idx)
  );

  // State, latched request and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      pend_mask <= '0;
      addr_lat  <= '0;
      bg_lat    <= '0;
      rom_req   <= 1'b0;
      rom_layer <= '0;
      rom_addr  <= '0;
      pix_valid <= 1'b0;
      pix_idx   <= '0;
      pix_layer <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend_mask <= pend_nxt;
      addr_lat  <= addr_nxt;
      bg_lat    <= bg_nxt;
      rom_req   <= rom_req_nxt;
      rom_layer <= rom_layer_nxt;
      rom_addr  <= rom_addr_nxt;
      pix_valid <= pix_valid_nxt;
      pix_idx   <= pix_idx_nxt;
      pix_layer <= pix_layer_nxt;
      overrun   <= overrun_nxt;
    end
  end

  // Next-state and next-output logic; rom_layer doubles as the layer under test
  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend_mask;
    addr_nxt      = addr_lat;
    bg_nxt        = bg_lat;
    rom_req_nxt   = 1'b0;
    rom_layer_nxt = rom_layer;
    rom_addr_nxt  = rom_addr;
    pix_valid_nxt = 1'b0;
    pix_idx_nxt   = pix_idx;
    pix_layer_nxt = pix_layer;
    overrun_nxt   = overrun;
    ovr_evt       = 1'b0;

    if (pixel_start) begin
      // A new request always wins; mid-scan it aborts the current pixel
      pend_nxt  = layer_hit;
      addr_nxt  = layer_addr;
      bg_nxt    = bg_idx;
      state_nxt = ISSUE;
      ovr_evt   = (state == ISSUE) || (state == WAIT);
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        ISSUE: begin
          if (!enc_any) begin
            pix_idx_nxt   = bg_lat;
            pix_layer_nxt = PL_W'(bg_layer_code(NUM_LAYERS));
            pix_valid_nxt = 1'b1;
            state_nxt     = DONE;
          end else begin
            rom_req_nxt   = 1'b1;
            rom_layer_nxt = enc_idx;
            for (int i = 0; i < NUM_LAYERS; i++) begin
              if (enc_idx == LAYER_W'(i)) begin
                rom_addr_nxt = addr_lat[i*ADDR_W +: ADDR_W];
                pend_nxt[i]  = 1'b0;
              end
            end
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (rom_data != IDX_W'(TRANSPARENT_IDX)) begin
            pix_idx_nxt   = rom_data;
            pix_layer_nxt = PL_W'(rom_layer);
            pix_valid_nxt = 1'b1;
            state_nxt     = DONE;
          end else begin
            state_nxt = ISSUE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // An overrun in the same cycle as frame_start leaves the flag set
    if (frame_start) overrun_nxt = 1'b0;
    if (ovr_evt)     overrun_nxt = 1'b1;
  end

`ifdef SPRITE_SEQ_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt;

  // Saturating overrun event counter, restarted each frame
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ovr_cnt <= '0;
    end else if (frame_start) begin
      ovr_cnt <= ovr_evt ? 8'd1 : 8'd0;
    end else if (ovr_evt && (ovr_cnt != 8'hFF)) begin
      ovr_cnt <= ovr_cnt + 8'd1;
    end
  end

  assign overrun_cnt = ovr_cnt;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sprite_layer_sequencer.sv
// Directed bench for sprite_layer_sequencer with a combinational ROM model.
module tb_sprite_layer_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pixel_start;
  logic [3:0]  layer_hit;
  logic [39:0] layer_addr;
  logic [3:0]  bg_idx;
  logic        rom_req;
  logic [1:0]  rom_layer;
  logic [9:0]  rom_addr;
  logic [3:0]  rom_data;
  logic        pix_valid;
  logic [3:0]  pix_idx;
  logic [2:0]  pix_layer;
  logic        overrun;
  logic        frame_start;
  logic [7:0]  overrun_cnt;

  logic [3:0]  tbl [4];
  logic [39:0] addr_v = {10'h3A0, 10'h2B1, 10'h1C2, 10'h0D3};

  int total = 0;
  int bad   = 0;

  int         cyc;
  int         n_valid, v_first, v_last;
  logic [3:0] v_idx;
  logic [2:0] v_lay;
  int         n_req;
  logic [1:0] req_lay  [8];
  logic [9:0] req_addr [8];

`ifdef SPRITE_SEQ_OVERRUN_CNT_EN
  localparam logic [7:0] CNT_ONE = 8'd1;
`else
  localparam logic [7:0] CNT_ONE = 8'd0;
`endif

  always #5 Clk = ~Clk;

  // ROM answers while the read strobe is high; junk otherwise to expose bad timing
  assign rom_data = rom_req ? tbl[rom_layer] : 4'hE;

  sprite_layer_sequencer dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pixel_start (pixel_start),
    .layer_hit   (layer_hit),
    .layer_addr  (layer_addr),
    .bg_idx      (bg_idx),
    .rom_req     (rom_req),
    .rom_layer   (rom_layer),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_valid   (pix_valid),
    .pix_idx     (pix_idx),
    .pix_layer   (pix_layer),
    .overrun     (overrun),
    .frame_start (frame_start),
    .overrun_cnt (overrun_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] exp_addr(input int i);
    return addr_v[i*10 +: 10];
  endfunction

  // Present a pixel request in the current cycle and restart observation at cycle 0
  task automatic start(input logic [3:0] hit, input logic [3:0] bg);
    layer_hit   = hit;
    layer_addr  = addr_v;
    bg_idx      = bg;
    pixel_start = 1'b1;
    cyc     = 0;
    n_valid = 0;
    v_first = -1;
    v_last  = -1;
    n_req   = 0;
  endtask

  // Advance one cycle and record what the DUT shows in it
  task automatic tick();
    @(negedge Clk);
    cyc++;
    pixel_start = 1'b0;
    frame_start = 1'b0;
    if (pix_valid) begin
      n_valid++;
      if (v_first < 0) v_first = cyc;
      v_last = cyc;
      v_idx  = pix_idx;
      v_lay  = pix_layer;
    end
    if (rom_req) begin
      if (n_req < 8) begin
        req_lay[n_req]  = rom_layer;
        req_addr[n_req] = rom_addr;
      end
      n_req++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    Reset_n     = 1'b0;
    pixel_start = 1'b0;
    frame_start = 1'b0;
    layer_hit   = '0;
    layer_addr  = '0;
    bg_idx      = '0;
    for (int i = 0; i < 4; i++) tbl[i] = 4'h0;

    repeat (2) @(negedge Clk);
    chk("rst_rom_req",   32'(rom_req),     32'h0);
    chk("rst_rom_layer", 32'(rom_layer),   32'h0);
    chk("rst_rom_addr",  32'(rom_addr),    32'h0);
    chk("rst_pix_valid", 32'(pix_valid),   32'h0);
    chk("rst_pix_idx",   32'(pix_idx),     32'h0);
    chk("rst_pix_layer", 32'(pix_layer),   32'h0);
    chk("rst_overrun",   32'(overrun),     32'h0);
    chk("rst_ovr_cnt",   32'(overrun_cnt), 32'h0);
    Reset_n = 1'b1;
    ticks(2);

    // No hits: background after two cycles, ROM untouched
    start(4'b0000, 4'd3);
    ticks(6);
    chk("nohit_cycle", 32'(v_first), 32'd2);
    chk("nohit_count", 32'(n_valid), 32'd1);
    chk("nohit_idx",   32'(v_idx),   32'h3);
    chk("nohit_layer", 32'(v_lay),   32'd4);
    chk("nohit_reads", 32'(n_req),   32'd0);

    // Priority: layer 1 beats layer 3 with a single read
    for (int i = 0; i < 4; i++) tbl[i] = 4'h6;
    start(4'b1010, 4'd2);
    ticks(8);
    chk("prio_cycle", 32'(v_first),     32'd3);
    chk("prio_count", 32'(n_valid),     32'd1);
    chk("prio_idx",   32'(v_idx),       32'h6);
    chk("prio_layer", 32'(v_lay),       32'd1);
    chk("prio_reads", 32'(n_req),       32'd1);
    chk("prio_rlay0", 32'(req_lay[0]),  32'd1);
    chk("prio_radr0", 32'(req_addr[0]), 32'(exp_addr(1)));

    // Transparent layer 1 falls through to layer 2
    tbl[1] = 4'h0;
    tbl[2] = 4'hA;
    start(4'b0110, 4'd2);
    ticks(9);
    chk("fall_cycle", 32'(v_first),     32'd5);
    chk("fall_idx",   32'(v_idx),       32'hA);
    chk("fall_layer", 32'(v_lay),       32'd2);
    chk("fall_reads", 32'(n_req),       32'd2);
    chk("fall_rlay0", 32'(req_lay[0]),  32'd1);
    chk("fall_rlay1", 32'(req_lay[1]),  32'd2);
    chk("fall_radr1", 32'(req_addr[1]), 32'(exp_addr(2)));

    // Every layer transparent: worst-case latency, background wins
    for (int i = 0; i < 4; i++) tbl[i] = 4'h0;
    start(4'b1111, 4'd9);
    ticks(14);
    chk("allt_cycle", 32'(v_first),     32'd10);
    chk("allt_count", 32'(n_valid),     32'd1);
    chk("allt_idx",   32'(v_idx),       32'h9);
    chk("allt_layer", 32'(v_lay),       32'd4);
    chk("allt_reads", 32'(n_req),       32'd4);
    chk("allt_rlay0", 32'(req_lay[0]),  32'd0);
    chk("allt_rlay3", 32'(req_lay[3]),  32'd3);
    chk("allt_radr0", 32'(req_addr[0]), 32'(exp_addr(0)));
    chk("allt_hold_layer", 32'(rom_layer), 32'd3);
    chk("allt_hold_addr",  32'(rom_addr),  32'(exp_addr(3)));
    chk("allt_ovr",   32'(overrun),     32'h0);

    // Overrun: second request arrives in ISSUE at cycle 3
    start(4'b1111, 4'd9);
    ticks(3);
    layer_hit   = 4'b0001;
    bg_idx      = 4'd8;
    tbl[0]      = 4'h5;
    pixel_start = 1'b1;
    tick();
    chk("ovr_flag",     32'(overrun),     32'h1);
    chk("ovr_cnt",      32'(overrun_cnt), 32'(CNT_ONE));
    chk("ovr_no_read",  32'(rom_req),     32'h0);
    ticks(5);
    chk("ovr_count",  32'(n_valid), 32'd1);
    chk("ovr_cycle",  32'(v_first), 32'd6);
    chk("ovr_idx",    32'(v_idx),   32'h5);
    chk("ovr_layer",  32'(v_lay),   32'd0);
    chk("ovr_reads",  32'(n_req),   32'd2);
    frame_start = 1'b1;
    tick();
    chk("ovr_clr_flag", 32'(overrun),     32'h0);
    chk("ovr_clr_cnt",  32'(overrun_cnt), 32'h0);

    // Request during DONE is accepted without overrun
    start(4'b0000, 4'd2);
    ticks(2);
    layer_hit   = 4'b0001;
    tbl[0]      = 4'h7;
    pixel_start = 1'b1;
    ticks(5);
    chk("done_count", 32'(n_valid), 32'd2);
    chk("done_first", 32'(v_first), 32'd2);
    chk("done_last",  32'(v_last),  32'd5);
    chk("done_idx",   32'(v_idx),   32'h7);
    chk("done_layer", 32'(v_lay),   32'd0);
    chk("done_ovr",   32'(overrun), 32'h0);

    // Overrun in WAIT together with frame_start: flag and count end at one
    for (int i = 0; i < 4; i++) tbl[i] = 4'h0;
    start(4'b1111, 4'd2);
    ticks(2);
    layer_hit   = 4'b0000;
    bg_idx      = 4'd1;
    pixel_start = 1'b1;
    frame_start = 1'b1;
    tick();
    chk("both_flag", 32'(overrun),     32'h1);
    chk("both_cnt",  32'(overrun_cnt), 32'(CNT_ONE));
    tick();
    chk("both_valid", 32'(pix_valid), 32'h1);
    chk("both_idx",   32'(pix_idx),   32'h1);
    chk("both_layer", 32'(pix_layer), 32'd4);
    ticks(2);

    // Asynchronous reset while waiting on the ROM
    start(4'b1111, 4'd9);
    ticks(2);
    Reset_n = 1'b0;
    #1;
    chk("arst_rom_req",   32'(rom_req),     32'h0);
    chk("arst_rom_layer", 32'(rom_layer),   32'h0);
    chk("arst_rom_addr",  32'(rom_addr),    32'h0);
    chk("arst_pix_idx",   32'(pix_idx),     32'h0);
    chk("arst_pix_layer", 32'(pix_layer),   32'h0);
    chk("arst_overrun",   32'(overrun),     32'h0);
    chk("arst_ovr_cnt",   32'(overrun_cnt), 32'h0);
    ticks(3);
    Reset_n = 1'b1;
    ticks(10);
    chk("arst_no_valid", 32'(n_valid), 32'd0);

    // Normal pixel after reset release
    tbl[2] = 4'hC;
    start(4'b0100, 4'd9);
    ticks(6);
    chk("post_cycle", 32'(v_first), 32'd3);
    chk("post_idx",   32'(v_idx),   32'hC);
    chk("post_layer", 32'(v_lay),   32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
